pcie_rx_detect_ctrl: RTL

PCIE_RX_DETECT_CTRL -- requirements
Module: pcie_rx_detect_ctrl

---
 rtl/pcie_phy_pkg.sv | 30 +++
 rtl/pcie_rx_detect_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared types and helpers for the PIPE receiver-detect controller.
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DETECT,
        SETTLE,
        GAP,
        DONE
    } rx_detect_state_e;

    localparam logic [2:0] RXSTATUS_RX_DETECTED = 3'b011;

    // Number of consecutive set bits starting at bit 0, looking at the low n bits only.
    function automatic logic [5:0] contig_count(input logic [31:0] mask, input int unsigned n);
        logic [5:0] cnt;
        logic       run;
        cnt = 6'd0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && (i < n) && mask[i]) begin
                cnt = cnt + 6'd1;
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pcie_rx_detect_ctrl.sv
// PIPE receiver-detect sequencer: pulses TxDetectRx, collects per-lane RxStatus, reports detected lanes.
// Optional zero-detect retry with an idle gap is built when RX_DETECT_RETRY_EN is defined.
module pcie_rx_detect_ctrl
    import pcie_phy_pkg::*;
#(
    parameter int unsigned MAX_NUM_LANES = 1,
    parameter int unsigned CLK_RATE      = 100,
    parameter int unsigned TIMEOUT_US    = 10,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned RETRY_MAX     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [MAX_NUM_LANES-1:0]   phy_phystatus_i,
    input  logic [3*MAX_NUM_LANES-1:0] phy_rxstatus_i,
    output logic                       phy_txdetectrx_o,
    output logic [MAX_NUM_LANES-1:0]   lane_status_o,
    output logic [5:0]                 num_active_lanes_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o
);

    localparam int unsigned    TIMEOUT_CYCLES = CLK_RATE * TIMEOUT_US;
    localparam int unsigned    TMR_MAX        = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned    TMR_W          = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef RX_DETECT_RETRY_EN
    localparam int unsigned    RETRY_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    // SETTLE's low cycle counts toward the gap, so TxDetectRx stays low exactly GAP_CYCLES between attempts.
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
`endif

    rx_detect_state_e           state_q, state_d;
    logic [MAX_NUM_LANES-1:0]   seen_q, seen_d;
    logic [MAX_NUM_LANES-1:0]   det_q, det_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic                       sticky_q, sticky_d;
`ifdef RX_DETECT_RETRY_EN
    logic [RETRY_W-1:0]         retry_q, retry_d;
`endif

    logic                       txdetectrx_q, txdetectrx_d;
    logic [MAX_NUM_LANES-1:0]   lane_status_q, lane_status_d;
    logic [5:0]                 num_active_q, num_active_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;

    logic [MAX_NUM_LANES-1:0]   rx_ok;
    logic [MAX_NUM_LANES-1:0]   new_lanes;

    always_comb begin
        for (int i = 0; i < MAX_NUM_LANES; i++) begin
            rx_ok[i] = (phy_rxstatus_i[3*i +: 3] == RXSTATUS_RX_DETECTED);
        end
    end

    assign new_lanes = phy_phystatus_i & ~seen_q;

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d  = state_q;
        seen_d   = seen_q;
        det_d    = det_q;
        timer_d  = timer_q;
        sticky_d = sticky_q;
`ifdef RX_DETECT_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = DETECT;
                    seen_d   = '0;
                    det_d    = '0;
                    timer_d  = '0;
                    sticky_d = 1'b0;
`ifdef RX_DETECT_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            DETECT: begin
                seen_d  = seen_q | new_lanes;
                det_d   = det_q | (new_lanes & rx_ok);
                timer_d = timer_q + 1'b1;
                // Completion in the same cycle as the last timer tick wins over the timeout.
                if (&seen_d) begin
                    state_d = SETTLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    sticky_d = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                timer_d = '0;
                state_d = DONE;
`ifdef RX_DETECT_RETRY_EN
                if ((det_q == '0) && (retry_q < RETRY_W'(RETRY_MAX))) begin
                    state_d = GAP;
                end
`endif
            end
`ifdef RX_DETECT_RETRY_EN
            GAP: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == GAP_LAST) begin
                    state_d = DETECT;
                    retry_d = retry_q + 1'b1;
                    seen_d  = '0;
                    det_d   = '0;
                    timer_d = '0;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        txdetectrx_d  = (state_d == DETECT);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        timeout_d     = (state_d == DONE) && sticky_q;
        lane_status_d = lane_status_q;
        num_active_d  = num_active_q;
        if (state_q == SETTLE) begin
            lane_status_d = det_q;
            num_active_d  = contig_count(32'(det_q), MAX_NUM_LANES);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            seen_q        <= '0;
            det_q         <= '0;
            timer_q       <= '0;
            sticky_q      <= 1'b0;
`ifdef RX_DETECT_RETRY_EN
            retry_q       <= '0;
`endif
            txdetectrx_q  <= 1'b0;
            lane_status_q <= '0;
            num_active_q  <= 6'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            seen_q        <= seen_d;
            det_q         <= det_d;
            timer_q       <= timer_d;
            sticky_q      <= sticky_d;
`ifdef RX_DETECT_RETRY_EN
            retry_q       <= retry_d;
`endif
            txdetectrx_q  <= txdetectrx_d;
            lane_status_q <= lane_status_d;
            num_active_q  <= num_active_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign phy_txdetectrx_o   = txdetectrx_q;
    assign lane_status_o      = lane_status_q;
    assign num_active_lanes_o = num_active_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign timeout_o          = timeout_q;

endmodule
